// File: rtl/mux5_rr_arbiter.sv
// Purpose : round-robin arbiter + 3-bit select for the 5-input 32-bit shared-bus mux.
// Latency : 1 cycle from req to grant/sel; all outputs registered.
// Backpr. : owner holds grant while requesting; bounded to MAX_BURST cycles only while others wait.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      [4:0] level requests, bit i = mux input i
//   grant    [4:0] one-hot grant, zero when idle
//   sel      [2:0] binary index of owner (0..4); holds last value while idle
//   busy     high iff grant != 0
//   handoff  one-cycle pulse on the first cycle of every new grant
module mux5_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    output logic [4:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       handoff
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] owner, owner_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [4:0] grant_nxt;
    logic [2:0] sel_nxt;
    logic       handoff_nxt;
    logic [4:0] others;
    logic       new_grant;
    logic [2:0] win;

    // First set bit of mask scanning start, start+1, ... modulo 5.
    // Callers only use it with a non-zero mask.
    function automatic logic [2:0] pick(input logic [4:0] mask, input logic [2:0] start);
        logic [3:0] s;
        logic [2:0] res;
        logic       found;
        res   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s = {1'b0, start} + 4'(i);
            if (s >= 4'd5) begin
                s = s - 4'd5;
            end
            if (!found && mask[s[2:0]]) begin
                res   = s[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        grant_nxt   = grant;
        sel_nxt     = sel;
        handoff_nxt = 1'b0;
        new_grant   = 1'b0;
        win         = 3'd0;
        others      = req & ~(5'b00001 << owner);

        case (state)
            IDLE: begin
                if (req != 5'd0) begin
                    new_grant = 1'b1;
                    win       = pick(req, ptr);
                end
            end
            OWN: begin
                if (req[owner] && ((cnt < BURST_LIM) || (others == 5'd0))) begin
                    // Keep owner; counter saturates so a long solo burst cannot wrap.
                    cnt_nxt = (cnt == 4'hF) ? cnt : cnt + 4'd1;
                end else if (!req[owner]) begin
                    if (req != 5'd0) begin
                        // Release with others pending: hand over without an idle gap.
                        new_grant = 1'b1;
                        win       = pick(req, ptr);
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = 5'd0;
                    end
                end else begin
                    // Burst exhausted and someone else is waiting: preempt.
                    new_grant = 1'b1;
                    win       = pick(others, ptr);
                end
            end
        endcase

        if (new_grant) begin
            state_nxt   = OWN;
            owner_nxt   = win;
            grant_nxt   = 5'b00001 << win;
            sel_nxt     = win;
            cnt_nxt     = 4'd1;
            ptr_nxt     = (win == 3'd4) ? 3'd0 : win + 3'd1;
            handoff_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            owner   <= 3'd0;
            cnt     <= 4'd0;
            grant   <= 5'd0;
            sel     <= 3'd0;
            busy    <= 1'b0;
            handoff <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            grant   <= grant_nxt;
            sel     <= sel_nxt;
            busy    <= (grant_nxt != 5'd0);
            handoff <= handoff_nxt;
        end
    end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Purpose : directed self-checking bench for mux5_rr_arbiter (MAX_BURST 4 and 1).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : none; inputs are driven right after sampling.
module tb_mux5_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       handoff;

    logic [4:0] req1;
    logic [4:0] grant1;
    logic [2:0] sel1;
    logic       busy1;
    logic       handoff1;

    int checks = 0;
    int errors = 0;

    mux5_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .handoff (handoff)
    );

    mux5_rr_arbiter #(.MAX_BURST(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req1),
        .grant   (grant1),
        .sel     (sel1),
        .busy    (busy1),
        .handoff (handoff1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Burst-preemption expectations for cycles 1..9 with req = 00110.
    logic [4:0] burst_grant [9];
    logic       burst_ho    [9];

    initial begin
        burst_grant = '{5'b00010, 5'b00010, 5'b00010, 5'b00010,
                        5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00010};
        burst_ho    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held two cycles with all requests up.
        rst  = 1'b1;
        req  = 5'b11111;
        req1 = 5'b00000;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_handoff", 32'(handoff), 32'h0);
        rst = 1'b0;
        tick();
        check("first_grant", 32'(grant), 32'h01);
        check("first_handoff", 32'(handoff), 32'h1);

        // Single requester 3 held 10 cycles, then released.
        rst = 1'b1;
        req = 5'b01000;
        tick();
        rst = 1'b0;
        tick();
        check("single_c1_grant", 32'(grant), 32'h08);
        check("single_c1_sel", 32'(sel), 32'h3);
        check("single_c1_handoff", 32'(handoff), 32'h1);
        for (int c = 2; c <= 10; c++) begin
            tick();
            check($sformatf("single_c%0d_grant", c), 32'(grant), 32'h08);
            check($sformatf("single_c%0d_handoff", c), 32'(handoff), 32'h0);
        end
        req = 5'b00000;
        tick();
        check("single_rel_grant", 32'(grant), 32'h0);
        check("single_rel_sel", 32'(sel), 32'h3);
        check("single_rel_busy", 32'(busy), 32'h0);

        // Burst preemption between requesters 1 and 2.
        rst = 1'b1;
        req = 5'b00110;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick();
            check($sformatf("burst_c%0d_grant", c + 1), 32'(grant), 32'(burst_grant[c]));
            check($sformatf("burst_c%0d_handoff", c + 1), 32'(handoff), 32'(burst_ho[c]));
        end
        check("burst_c9_sel", 32'(sel), 32'h1);
        req = 5'b00000;
        tick();

        // Back-to-back release from owner 4 to requester 0.
        rst = 1'b1;
        req = 5'b10000;
        tick();
        rst = 1'b0;
        tick();
        check("b2b_owner4_sel", 32'(sel), 32'h4);
        req = 5'b10001;
        tick();
        check("b2b_hold_grant", 32'(grant), 32'h10);
        req = 5'b00001;
        tick();
        check("b2b_new_grant", 32'(grant), 32'h01);
        check("b2b_busy", 32'(busy), 32'h1);
        check("b2b_handoff", 32'(handoff), 32'h1);
        check("b2b_ptr_wrap", 32'(dut.ptr), 32'h1);
        req = 5'b00000;

        // Strict rotation with MAX_BURST = 1.
        rst  = 1'b1;
        req1 = 5'b11111;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr_k%0d_grant", k), 32'(grant1), 32'(5'b00001 << (k % 5)));
            check($sformatf("rr_k%0d_sel", k), 32'(sel1), 32'(k % 5));
        end
        req1 = 5'b00000;

        // Reset in the middle of a burst by owner 2.
        rst = 1'b1;
        req = 5'b00100;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("midrst_owner_grant", 32'(grant), 32'h04);
        rst = 1'b1;
        tick();
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_handoff", 32'(handoff), 32'h0);
        check("midrst_ptr", 32'(dut.ptr), 32'h0);
        rst = 1'b0;
        tick();
        check("midrst_regrant", 32'(grant), 32'h04);
        check("midrst_regrant_handoff", 32'(handoff), 32'h1);
        check("midrst_regrant_sel", 32'(sel), 32'h2);
        // ptr is now 3, so from idle requesters 0 and 1 resolve to 0 (scan 3,4,0).
        req = 5'b00000;
        tick();
        check("midrst_idle_sel", 32'(sel), 32'h2);
        req = 5'b00011;
        tick();
        check("midrst_next_grant", 32'(grant), 32'h01);
        req = 5'b00000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
